// File: rtl/fifo_rf_ctrl.sv
// Synchronous FIFO with its own register-file storage, occupancy counter,
// programmable almost-full/almost-empty decodes, synchronous flush and
// sticky overflow/underflow error flags. Single clock domain.
`timescale 1ns/1ps
module fifo_rf_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_BITS  = 9,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [DATA_BITS-1:0]  rd_data,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc, rd_acc, ovf_set, unf_set;

  // Status flags decode only the count register so they never glitch on input changes.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Show-ahead: the head entry is always visible without a read strobe.
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a full FIFO still takes a push
  // when rd_en is present. Flush swallows both requests and their errors.
  assign wr_acc  = wr_en & (~full | rd_en) & ~flush;
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign ovf_set = wr_en & full & ~rd_en & ~flush;
  assign unf_set = rd_en & empty & ~flush;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
    // A fresh error in the clearing cycle must not be lost.
    overflow_d  = ovf_set | (overflow_q & ~err_clr);
    underflow_d = unf_set | (underflow_q & ~err_clr);
  end

  // Control state register; storage is deliberately left out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
